// File: rtl/rv32_types.sv
// rv32_types: shared types and constants for the rv32 pipeline controller.
//   fwd_sel_t   operand source select (regfile, EX, MEM, WB)
//   RV_ZERO_REG architectural x0, which never takes part in a dependency
package rv32_types;
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;
    localparam logic [4:0] RV_ZERO_REG = 5'd0;
endpackage

// File: rtl/rv32_fwd_unit.sv
// rv32_fwd_unit: dependency match and forward select for one decode source register.
//   rs, use_rs                 source register and whether decode reads it
//   ex_/mem_/wb_rd, _we        destination and write-enable of the three producers
//   ex_match                   rs depends on the instruction in exec
//   any_match                  rs depends on any in-flight producer
//   sel                        youngest producer (EX > MEM > WB), regfile when forwarding is off
module rv32_fwd_unit
    import rv32_types::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic [4:0] rs,
    input  logic       use_rs,
    input  logic [4:0] ex_rd,
    input  logic       ex_we,
    input  logic [4:0] mem_rd,
    input  logic       mem_we,
    input  logic [4:0] wb_rd,
    input  logic       wb_we,
    output logic       ex_match,
    output logic       any_match,
    output logic [1:0] sel
);
    logic live, mem_match, wb_match;
    fwd_sel_t src;
    assign live      = use_rs && rs != RV_ZERO_REG;
    assign ex_match  = live && ex_we && ex_rd == rs;
    assign mem_match = live && mem_we && mem_rd == rs;
    assign wb_match  = live && wb_we && wb_rd == rs;
    assign any_match = ex_match || mem_match || wb_match;
    assign src = FWD_EN == 0 ? FWD_RF :
                 ex_match    ? FWD_EX :
                 mem_match   ? FWD_MEM :
                 wb_match    ? FWD_WB : FWD_RF;
    assign sel = src;
endmodule

// File: rtl/rv32_pipeline_ctrl.sv
// rv32_pipeline_ctrl: PC register, hazard/stall/flush priority and performance counters.
//   clk, resetn (sync, active-low)
//   instr_ready, exec_jump, exec_jump_addr, mem_stall, wb_valid      pipeline status
//   dec_rs1/2, dec_use_rs1/2, ex_*/mem_*/wb_* rd/we, ex_load         dependency inputs
//   pc, next_pc                                                      fetch PC, registered and next
//   fetch_stall, dec_stall, flush_fetch, flush_dec, bubble_ex        pipeline control
//   fwd1_sel, fwd2_sel, jump_misalign                                operand selects, misaligned jump
//   cnt_cycle, cnt_instret, cnt_stall, cnt_flush                     wrapping counters
module rv32_pipeline_ctrl
    import rv32_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FWD_EN   = 1,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             instr_ready,
    input  logic             exec_jump,
    input  logic [31:0]      exec_jump_addr,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_we,
    input  logic             ex_load,
    input  logic [4:0]       mem_rd,
    input  logic             mem_we,
    input  logic [4:0]       wb_rd,
    input  logic             wb_we,
    input  logic             wb_valid,
    input  logic             mem_stall,
    output logic [31:0]      pc,
    output logic [31:0]      next_pc,
    output logic             fetch_stall,
    output logic             dec_stall,
    output logic             flush_fetch,
    output logic             flush_dec,
    output logic             bubble_ex,
    output logic [1:0]       fwd1_sel,
    output logic [1:0]       fwd2_sel,
    output logic             jump_misalign,
    output logic [CNT_W-1:0] cnt_cycle,
    output logic [CNT_W-1:0] cnt_instret,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush
);
    logic       ex1, ex2, any1, any2, hazard, jump_taken, haz_taken, idle_fetch;
    logic [1:0] sel1, sel2;

    rv32_fwd_unit #(.FWD_EN(FWD_EN)) u_fwd1 (
        .rs(dec_rs1), .use_rs(dec_use_rs1),
        .ex_rd(ex_rd), .ex_we(ex_we), .mem_rd(mem_rd), .mem_we(mem_we),
        .wb_rd(wb_rd), .wb_we(wb_we),
        .ex_match(ex1), .any_match(any1), .sel(sel1)
    );

    rv32_fwd_unit #(.FWD_EN(FWD_EN)) u_fwd2 (
        .rs(dec_rs2), .use_rs(dec_use_rs2),
        .ex_rd(ex_rd), .ex_we(ex_we), .mem_rd(mem_rd), .mem_we(mem_we),
        .wb_rd(wb_rd), .wb_we(wb_we),
        .ex_match(ex2), .any_match(any2), .sel(sel2)
    );

    // With forwarding only a load in exec cannot be bypassed; without it every dependency waits.
    assign hazard = FWD_EN != 0 ? (ex1 || ex2) && ex_load : any1 || any2;

    // Each level is taken only when no higher-priority level holds; reset masks all of them.
    assign jump_taken = resetn && !mem_stall && exec_jump;
    assign haz_taken  = resetn && !mem_stall && !exec_jump && hazard;
    assign idle_fetch = resetn && !mem_stall && !exec_jump && !hazard && !instr_ready;

    assign fetch_stall   = (resetn && mem_stall) || haz_taken || idle_fetch;
    assign dec_stall     = (resetn && mem_stall) || haz_taken;
    assign bubble_ex     = haz_taken;
    assign flush_fetch   = jump_taken || idle_fetch;
    assign flush_dec     = jump_taken;
    assign jump_misalign = jump_taken && exec_jump_addr[1:0] != 2'b00;
    assign fwd1_sel      = resetn ? sel1 : FWD_RF;
    assign fwd2_sel      = resetn ? sel2 : FWD_RF;
    assign next_pc = !resetn    ? RESET_PC :
                     fetch_stall ? pc :
                     jump_taken  ? {exec_jump_addr[31:2], 2'b00} : pc + 32'd4;

    always_ff @(posedge clk) begin
        pc <= next_pc;
        if (!resetn) begin
            cnt_cycle   <= '0;
            cnt_instret <= '0;
            cnt_stall   <= '0;
            cnt_flush   <= '0;
        end else begin
            cnt_cycle   <= cnt_cycle + CNT_W'(1);
            cnt_instret <= cnt_instret + CNT_W'(wb_valid);
            cnt_stall   <= cnt_stall + CNT_W'(fetch_stall);
            cnt_flush   <= cnt_flush + CNT_W'(jump_taken);
        end
    end
endmodule

// File: tb/tb_rv32_pipeline_ctrl.sv
// tb_rv32_pipeline_ctrl: two controllers (forwarding on with 32-bit counters, forwarding off with
// 4-bit counters) driven by shared inputs and checked against a behavioural model every cycle.
module tb_rv32_pipeline_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        instr_ready, exec_jump, use1, use2, ex_we, ex_load, mem_we, wb_we, wb_valid, mem_stall;
    logic [31:0] jaddr;
    logic [4:0]  rs1, rs2, ex_rd, mem_rd, wb_rd;
    logic [31:0] pc_o[2], npc_o[2];
    logic        fs[2], ds[2], ff[2], fd[2], bx[2], mis[2];
    logic [1:0]  f1[2], f2[2];
    logic [31:0] ca_cyc, ca_ins, ca_stl, ca_fls;
    logic [3:0]  cb_cyc, cb_ins, cb_stl, cb_fls;
    int          vec = 0, miss = 0;
    logic [31:0] mpc[2];
    logic [31:0] mc[2][4];
    bit          mvalid = 0;

    typedef struct {
        logic [31:0] npc;
        logic        fs, ds, ff, fd, bx, mis, jt;
        logic [1:0]  f1, f2;
    } exp_t;

    always #5 clk = ~clk;

    rv32_pipeline_ctrl #(.RESET_PC(32'h100), .FWD_EN(1), .CNT_W(32)) dut_a (
        .clk(clk), .resetn(resetn), .instr_ready(instr_ready), .exec_jump(exec_jump),
        .exec_jump_addr(jaddr), .dec_rs1(rs1), .dec_rs2(rs2), .dec_use_rs1(use1), .dec_use_rs2(use2),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load), .mem_rd(mem_rd), .mem_we(mem_we),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_valid(wb_valid), .mem_stall(mem_stall),
        .pc(pc_o[0]), .next_pc(npc_o[0]), .fetch_stall(fs[0]), .dec_stall(ds[0]),
        .flush_fetch(ff[0]), .flush_dec(fd[0]), .bubble_ex(bx[0]), .fwd1_sel(f1[0]), .fwd2_sel(f2[0]),
        .jump_misalign(mis[0]), .cnt_cycle(ca_cyc), .cnt_instret(ca_ins), .cnt_stall(ca_stl),
        .cnt_flush(ca_fls)
    );

    rv32_pipeline_ctrl #(.RESET_PC(32'h100), .FWD_EN(0), .CNT_W(4)) dut_b (
        .clk(clk), .resetn(resetn), .instr_ready(instr_ready), .exec_jump(exec_jump),
        .exec_jump_addr(jaddr), .dec_rs1(rs1), .dec_rs2(rs2), .dec_use_rs1(use1), .dec_use_rs2(use2),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load), .mem_rd(mem_rd), .mem_we(mem_we),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_valid(wb_valid), .mem_stall(mem_stall),
        .pc(pc_o[1]), .next_pc(npc_o[1]), .fetch_stall(fs[1]), .dec_stall(ds[1]),
        .flush_fetch(ff[1]), .flush_dec(fd[1]), .bubble_ex(bx[1]), .fwd1_sel(f1[1]), .fwd2_sel(f2[1]),
        .jump_misalign(mis[1]), .cnt_cycle(cb_cyc), .cnt_instret(cb_ins), .cnt_stall(cb_stl),
        .cnt_flush(cb_fls)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the current inputs and the model PC of one controller.
    function automatic exp_t predict(bit fwd, logic [31:0] cur);
        exp_t        e;
        logic [4:0]  rd[3], rs[2];
        logic        we[3], us[2];
        logic [1:0]  sel[2];
        bit          dep, load_dep;
        e = '{npc: 32'h100, default: '0};
        if (!resetn) return e;
        rd = '{ex_rd, mem_rd, wb_rd};
        we = '{ex_we, mem_we, wb_we};
        rs = '{rs1, rs2};
        us = '{use1, use2};
        dep = 0;
        load_dep = 0;
        for (int s = 0; s < 2; s++) begin
            sel[s] = 2'd0;
            for (int k = 2; k >= 0; k--)
                if (us[s] && we[k] && rs[s] == rd[k] && rs[s] != 5'd0) begin
                    sel[s] = 2'(k + 1);
                    dep = 1;
                    if (k == 0 && ex_load) load_dep = 1;
                end
        end
        e.f1 = fwd ? sel[0] : 2'd0;
        e.f2 = fwd ? sel[1] : 2'd0;
        e.npc = cur;
        if (mem_stall) begin
            e.fs = 1; e.ds = 1;
        end else if (exec_jump) begin
            e.ff = 1; e.fd = 1; e.jt = 1;
            e.mis = jaddr % 4 != 0;
            e.npc = jaddr & ~32'd3;
        end else if (fwd ? load_dep : dep) begin
            e.fs = 1; e.ds = 1; e.bx = 1;
        end else if (!instr_ready) begin
            e.fs = 1; e.ff = 1;
        end else
            e.npc = cur + 4;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got[4];
        logic [31:0] mask;
        for (int i = 0; i < 2; i++) begin
            e = predict(i == 0, mpc[i]);
            mask = i == 0 ? 32'hffff_ffff : 32'hf;
            if (mvalid) begin
                got = i == 0 ? '{ca_cyc, ca_ins, ca_stl, ca_fls}
                             : '{32'(cb_cyc), 32'(cb_ins), 32'(cb_stl), 32'(cb_fls)};
                chk($sformatf("u%0d.pc", i), pc_o[i], mpc[i]);
                chk($sformatf("u%0d.next_pc", i), npc_o[i], e.npc);
                chk($sformatf("u%0d.ctl", i), {fs[i], ds[i], ff[i], fd[i], bx[i], mis[i]},
                    {e.fs, e.ds, e.ff, e.fd, e.bx, e.mis});
                chk($sformatf("u%0d.fwd", i), {f1[i], f2[i]}, {e.f1, e.f2});
                for (int k = 0; k < 4; k++)
                    chk($sformatf("u%0d.cnt%0d", i, k), got[k], mc[i][k] & mask);
            end
            if (!resetn) begin
                mpc[i] = 32'h100;
                for (int k = 0; k < 4; k++) mc[i][k] = 0;
            end else begin
                mpc[i] = e.npc;
                mc[i][0] += 1;
                mc[i][1] += 32'(wb_valid);
                mc[i][2] += 32'(e.fs);
                mc[i][3] += 32'(e.jt);
            end
        end
        if (!resetn) mvalid = 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_ready = 1; exec_jump = 0; jaddr = 0; mem_stall = 0; wb_valid = 0;
        rs1 = 0; rs2 = 0; use1 = 0; use2 = 0;
        ex_rd = 0; ex_we = 0; ex_load = 0; mem_rd = 0; mem_we = 0; wb_rd = 0; wb_we = 0;
    endtask

    initial begin
        logic [31:0] p;
        idle();
        resetn = 0;
        mem_stall = 1;
        exec_jump = 1;
        jaddr = 32'h40;
        step();
        step();
        #1;
        chk("rst.pc", pc_o[0], 32'h100);
        chk("rst.next_pc", npc_o[0], 32'h100);
        chk("rst.stall", {fs[0], ds[0], ff[0], fd[0]}, 4'b0000);
        chk("rst.cycle", ca_cyc, 0);
        resetn = 1;
        mem_stall = 0;
        exec_jump = 0;
        step();
        chk("boot.pc1", pc_o[0], 32'h104);
        chk("boot.cycle", ca_cyc, 1);
        step();
        chk("boot.pc2", pc_o[0], 32'h108);

        exec_jump = 1;
        jaddr = 32'h2002;
        #1;
        chk("jmp.flush", {ff[0], fd[0], mis[0]}, 3'b111);
        chk("jmp.next_pc", npc_o[0], 32'h2000);
        step();
        exec_jump = 0;
        chk("jmp.pc", pc_o[0], 32'h2000);
        chk("jmp.cnt_flush", ca_fls, 1);

        p = pc_o[0];
        ex_load = 1; ex_we = 1; ex_rd = 5; use1 = 1; rs1 = 5;
        #1;
        chk("lu.stall", {fs[0], bx[0]}, 2'b11);
        chk("lu.next_pc", npc_o[0], p);
        step();
        ex_load = 0; ex_we = 0; mem_we = 1; mem_rd = 5;
        #1;
        chk("lu.pc", pc_o[0], p);
        chk("lu.fwd1", f1[0], 2);
        chk("lu.nostall", fs[0], 0);
        step();

        ex_we = 1; ex_rd = 7; mem_we = 1; mem_rd = 7; rs1 = 7;
        #1;
        chk("fwd.ex_wins", f1[0], 1);
        chk("fwd.off_sel", f1[1], 0);
        chk("fwd.off_stall", fs[1], 1);
        ex_rd = 0; rs1 = 0; mem_we = 0;
        #1;
        chk("fwd.x0_sel", f1[0], 0);
        chk("fwd.x0_stall", {fs[0], fs[1]}, 2'b00);
        step();

        idle();
        resetn = 0;
        step();
        resetn = 1;
        ex_we = 1; ex_rd = 3; use2 = 1; rs2 = 3;
        #1;
        chk("nf.stall0", fs[1], 1);
        step();
        ex_we = 0; mem_we = 1; mem_rd = 3;
        step();
        mem_we = 0; wb_we = 1; wb_rd = 3;
        step();
        wb_we = 0;
        #1;
        chk("nf.released", fs[1], 0);
        chk("nf.cnt_stall", 32'(cb_stl), 3);
        step();

        p = pc_o[0];
        mem_stall = 1; exec_jump = 1; jaddr = 32'h300;
        #1;
        chk("ms.noflush", {ff[0], fd[0]}, 2'b00);
        chk("ms.next_pc", npc_o[0], p);
        step();
        chk("ms.pc1", pc_o[0], p);
        step();
        chk("ms.pc2", pc_o[0], p);
        mem_stall = 0;
        #1;
        chk("ms.jump", ff[0], 1);
        step();
        exec_jump = 0;
        chk("ms.target", pc_o[0], 32'h300);

        for (int n = 0; n < 1500; n++) begin
            resetn      = $urandom_range(0, 40) != 0;
            instr_ready = $urandom_range(0, 4) != 0;
            exec_jump   = $urandom_range(0, 7) == 0;
            mem_stall   = $urandom_range(0, 7) == 0;
            jaddr       = $urandom;
            rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
            ex_rd = 5'($urandom_range(0, 7)); mem_rd = 5'($urandom_range(0, 7));
            wb_rd = 5'($urandom_range(0, 7));
            use1 = 1'($urandom); use2 = 1'($urandom);
            ex_we = 1'($urandom); ex_load = 1'($urandom); mem_we = 1'($urandom);
            wb_we = 1'($urandom); wb_valid = 1'($urandom);
            step();
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
